// File: rtl/array_tpu_seq_pkg.sv
// array_tpu_seq_pkg: shared state encoding, defaults and stream-length helper for the array sequencer
package array_tpu_seq_pkg;
  localparam int CNTW_DEF = 16;
  typedef enum logic [2:0] {IDLE, CLR, WLOAD, STREAM, DONE} state_t;
  function automatic int stream_len(int m, int h, int w);
    return m + h + w - 1;
  endfunction
endpackage

// File: rtl/array_tpu_seq_win.sv
// array_tpu_seq_win: per-lane skewed window, bit i high while base+i <= t < base+i+len
module array_tpu_seq_win #(
  parameter int N    = 4,
  parameter int CNTW = 16
) (
  input  logic [CNTW-1:0] t,
  input  logic [CNTW-1:0] base,
  input  logic [CNTW-1:0] len,
  output logic [N-1:0]    win
);
  for (genvar i = 0; i < N; i++) begin : g_bit
    logic [CNTW-1:0] lo;
    assign lo = base + CNTW'(i);
    assign win[i] = (t >= lo) && (t < lo + len);
  end
endmodule

// File: rtl/array_tpu_seq.sv
// array_tpu_seq: turns a start command into skewed enable/clear vectors and feeder strobes for the systolic MAC array
module array_tpu_seq
  import array_tpu_seq_pkg::*;
#(
  parameter int HEIGHT = 256,
  parameter int WIDTH  = 256,
  parameter int CNTW   = CNTW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNTW-1:0]   cfg_m,
  input  logic              cfg_keep_w,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              wght_rd,
  output logic              ifm_rd,
  output logic [HEIGHT-1:0] en_i,
  output logic [HEIGHT-1:0] clr_i,
  output logic [WIDTH-1:0]  en_w,
  output logic [WIDTH-1:0]  clr_w,
  output logic [WIDTH-1:0]  en_o,
  output logic [WIDTH-1:0]  clr_o,
  output logic [WIDTH-1:0]  ofm_vld
);
  localparam logic [CNTW-1:0] H_CNT  = CNTW'(HEIGHT);
  localparam logic [CNTW-1:0] H_LAST = CNTW'(HEIGHT - 1);
  state_t st, st_n;
  logic [CNTW-1:0] cnt, cnt_n, m_q, m_n, l_last;
  logic keep_q, keep_n, acc;
  logic [HEIGHT-1:0] win_i;
  logic [WIDTH-1:0] win_o, win_v;
  assign acc    = (st == IDLE) && start && (cfg_m != '0);
  assign m_n    = acc ? cfg_m : m_q;
  assign keep_n = acc ? cfg_keep_w : keep_q;
  assign l_last = CNTW'(stream_len(int'(m_q), HEIGHT, WIDTH) - 1);
  // next state and shared phase counter (k in WLOAD, t in STREAM); abort wins outside IDLE
  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    case (st)
      IDLE: begin
        st_n  = acc ? CLR : IDLE;
        cnt_n = '0;
      end
      CLR: begin
        st_n  = keep_q ? STREAM : WLOAD;
        cnt_n = '0;
      end
      WLOAD: begin
        st_n  = (cnt == H_LAST) ? STREAM : WLOAD;
        cnt_n = (cnt == H_LAST) ? '0 : cnt + 1'b1;
      end
      STREAM: begin
        st_n  = (cnt == l_last) ? DONE : STREAM;
        cnt_n = (cnt == l_last) ? '0 : cnt + 1'b1;
      end
      default: begin
        st_n  = IDLE;
        cnt_n = '0;
      end
    endcase
    if (abort && st != IDLE) begin
      st_n  = IDLE;
      cnt_n = '0;
    end
  end
  array_tpu_seq_win #(.N(HEIGHT), .CNTW(CNTW)) u_win_i (.t(cnt_n), .base('0),   .len(m_q),         .win(win_i));
  array_tpu_seq_win #(.N(WIDTH),  .CNTW(CNTW)) u_win_o (.t(cnt_n), .base('0),   .len(m_q + H_CNT), .win(win_o));
  array_tpu_seq_win #(.N(WIDTH),  .CNTW(CNTW)) u_win_v (.t(cnt_n), .base(H_CNT), .len(m_q),         .win(win_v));
  // control state and latched tile configuration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      cnt    <= '0;
      m_q    <= '0;
      keep_q <= 1'b0;
    end else begin
      st     <= st_n;
      cnt    <= cnt_n;
      m_q    <= m_n;
      keep_q <= keep_n;
    end
  end
  // outputs registered from the next state so every output is a clean flop (Moore)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      wght_rd <= 1'b0;
      ifm_rd  <= 1'b0;
      en_i    <= '0;
      clr_i   <= '0;
      en_w    <= '0;
      clr_w   <= '0;
      en_o    <= '0;
      clr_o   <= '0;
      ofm_vld <= '0;
    end else begin
      busy    <= st_n != IDLE;
      done    <= st_n == DONE;
      err     <= (st == IDLE) && start && (cfg_m == '0);
      wght_rd <= st_n == WLOAD;
      ifm_rd  <= (st_n == STREAM) && (cnt_n < m_q);
      en_i    <= (st_n == STREAM) ? win_i : '0;
      clr_i   <= {HEIGHT{st_n == CLR}};
      en_w    <= {WIDTH{st_n == WLOAD}};
      clr_w   <= {WIDTH{(st_n == CLR) && !keep_n}};
      en_o    <= (st_n == STREAM) ? win_o : '0;
      clr_o   <= {WIDTH{st_n == CLR}};
      ofm_vld <= (st_n == STREAM) ? win_v : '0;
    end
  end
endmodule

// File: tb/tb_array_tpu_seq.sv
// tb_array_tpu_seq: directed and random checks of the sequencer against a cycle-age reference model
module tb_array_tpu_seq;
  localparam int H = 4, W = 3, CW = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, keep = 1'b0, abort = 1'b0;
  logic [CW-1:0] cfg_m = '0;
  logic busy, done, err, wght_rd, ifm_rd;
  logic [H-1:0] en_i, clr_i;
  logic [W-1:0] en_w, clr_w, en_o, clr_o, ofm_vld;
  logic [27:0] obs;
  int tests = 0, fails = 0, nd;
  bit act = 0, errp = 0, lk = 0;
  int age = 0, lm = 0;

  array_tpu_seq #(.HEIGHT(H), .WIDTH(W), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_m(cfg_m), .cfg_keep_w(keep), .abort(abort),
    .busy(busy), .done(done), .err(err), .wght_rd(wght_rd), .ifm_rd(ifm_rd),
    .en_i(en_i), .clr_i(clr_i), .en_w(en_w), .clr_w(clr_w), .en_o(en_o), .clr_o(clr_o),
    .ofm_vld(ofm_vld)
  );

  always #5 clk = ~clk;
  assign obs = {busy, done, err, wght_rd, ifm_rd, en_i, clr_i, en_w, clr_w, en_o, clr_o, ofm_vld};

  // expected outputs from the age (cycles since accept) of the current tile
  function automatic logic [27:0] expect_out();
    logic [H-1:0] ei;
    logic [W-1:0] eo, ov;
    int s, l, t;
    bit st, wl;
    if (!act) return {2'b00, errp, 25'b0};
    s  = lk ? 2 : H + 2;
    l  = lm + H + W - 1;
    t  = age - s;
    st = (age >= s) && (age < s + l);
    wl = !lk && age >= 2 && age <= H + 1;
    for (int h = 0; h < H; h++) ei[h] = st && t >= h && t < h + lm;
    for (int w = 0; w < W; w++) begin
      eo[w] = st && t >= w && t < w + lm + H;
      ov[w] = st && t >= w + H && t < w + H + lm;
    end
    return {1'b1, age == s + l, 1'b0, wl, st && t < lm, ei, {H{age == 1}}, {W{wl}},
            {W{age == 1 && !lk}}, eo, {W{age == 1}}, ov};
  endfunction

  task automatic model_step();
    if (!act) begin
      errp = start && cfg_m == 0;
      if (start && cfg_m != 0) begin
        act = 1; age = 1; lm = int'(cfg_m); lk = keep;
      end
    end else begin
      errp = 0;
      if (abort || age == (lk ? 2 : H + 2) + lm + H + W - 1) act = 0;
      else age++;
    end
  endtask

  task automatic check(string tag);
    logic [27:0] e;
    e = expect_out();
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, e);
    end
  endtask

  task automatic tick(string tag);
    model_step();
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic run(int n, string tag);
    repeat (n) tick(tag);
  endtask

  task automatic cmd(int m, bit k, string tag);
    start = 1'b1; cfg_m = CW'(m); keep = k;
    tick(tag);
    start = 1'b0; cfg_m = CW'($urandom); keep = 1'($urandom);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset");
    rst = 1'b0;
    run(1, "idle");
    cmd(2, 0, "s1_clr");
    run(14, "s1");
    cmd(2, 1, "keep_clr");
    run(10, "keep");
    cmd(0, 0, "err");
    run(2, "err_idle");
    start = 1'b1; cfg_m = 2; keep = 1'b0; nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 16) start = 1'b0;
      tick("b2b");
      nd += int'(done);
    end
    tests++;
    assert (nd == 2) else begin
      fails++;
      $error("FAIL b2b_done_count: observed %0d expected 2", nd);
    end
    cmd(2, 0, "ab");
    run(7, "ab");
    abort = 1'b1;
    tick("abort");
    abort = 1'b0;
    run(2, "ab_idle");
    cmd(2, 0, "after_ab");
    run(14, "after_ab");
    abort = 1'b1;
    cmd(3, 0, "ab_start");
    abort = 1'b0;
    run(17, "ab_start");
    cmd(2, 0, "rs");
    run(8, "rs");
    #3 rst = 1'b1;
    #1 act = 0; errp = 0;
    check("rst_async");
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_hold");
    cmd(2, 0, "post_rst");
    run(14, "post_rst");
    repeat (1500) begin
      start = ($urandom_range(0, 3) == 0);
      cfg_m = CW'($urandom_range(0, 6));
      keep  = 1'($urandom);
      abort = ($urandom_range(0, 40) == 0);
      tick("rand");
    end
    start = 1'b0; abort = 1'b0;
    run(40, "drain");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
